// File: rtl/rename_dispatch_controller_if.sv
// Decode-group / credit bundle between the decode stage and the rename dispatch gate.
// master drives the decode group and credits; slave is the dispatch controller.
interface rename_dispatch_controller_if #(
   parameter int unsigned ROB_CNT_W = 6
);
   logic                 flush;
   logic                 group_valid;
   logic [2:0]           slot_valid;
   logic [2:0]           need_reg;
   logic [2:0]           need_lsq;
   logic [2:0]           rename_ready;
   logic [2:0]           lsq_alloc_ready;
   logic [ROB_CNT_W-1:0] rob_free_count;
   logic [2:0]           dispatch_valid;
   logic                 group_accept;
   logic                 recovering;
   logic [1:0]           stall_reason;
   logic                 stall_timeout;

   modport master (
      output flush, group_valid, slot_valid, need_reg, need_lsq, rename_ready,
             lsq_alloc_ready, rob_free_count,
      input  dispatch_valid, group_accept, recovering, stall_reason, stall_timeout
   );

   modport slave (
      input  flush, group_valid, slot_valid, need_reg, need_lsq, rename_ready,
             lsq_alloc_ready, rob_free_count,
      output dispatch_valid, group_accept, recovering, stall_reason, stall_timeout
   );
endinterface

// File: rtl/rename_dispatch_controller.sv
// In-order 3-wide rename dispatch gate. Grants the longest prefix of the still-pending decode
// slots that fits the RAT, LSQ and ROB credits, holds partially dispatched groups, and blocks
// dispatch for a recovery window after a flush.
// Optional feature: define DISPATCH_PERF_CNT_EN to add the perf_disp_cnt / perf_stall_cnt
// counters and ports.
module rename_dispatch_controller #(
   parameter int unsigned ROB_CNT_W   = 6,
   parameter int unsigned FLUSH_WAIT  = 2,
   parameter int unsigned STALL_LIMIT = 255,
   parameter int unsigned STALL_W     = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   rename_dispatch_controller_if.slave       bus
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [31:0]                       perf_disp_cnt,
   output logic [31:0]                       perf_stall_cnt
`endif
);

   localparam int unsigned RcntW = (FLUSH_WAIT < 2) ? 1 : $clog2(FLUSH_WAIT + 1);

   typedef enum logic {StRun, StRecover} state_e;

   state_e             state_q;
   logic [2:0]         pending_q;
   logic [RcntW-1:0]   rcnt_q;
   logic [STALL_W-1:0] wdog_q;
   logic               stall_timeout_q;

   logic [1:0] c_reg, c_lsq, c_rob;
   logic [1:0] sum_reg, sum_lsq, sum_rob;
   logic [2:0] eff, grant_raw, grant;
   logic [1:0] reason_raw;
   logic       blocked, run_ok, accept;

   function automatic logic [1:0] therm_to_cnt(input logic [2:0] t);
      if (t[2])      return 2'd3;
      else if (t[1]) return 2'd2;
      else if (t[0]) return 2'd1;
      else           return 2'd0;
   endfunction

   // Credit decode and in-order prefix grant walk over the effective slots.
   always_comb begin
      c_reg      = therm_to_cnt(bus.rename_ready);
      c_lsq      = therm_to_cnt(bus.lsq_alloc_ready);
      c_rob      = (bus.rob_free_count >= ROB_CNT_W'(3)) ? 2'd3 : bus.rob_free_count[1:0];
      eff        = pending_q & bus.slot_valid & {3{bus.group_valid}};
      sum_reg    = 2'd0;
      sum_lsq    = 2'd0;
      sum_rob    = 2'd0;
      blocked    = 1'b0;
      grant_raw  = 3'b000;
      reason_raw = 2'b00;
      for (int i = 0; i < 3; i++) begin
         if (eff[i] && !blocked) begin
            // At most three slots, so a 2-bit sum never wraps.
            sum_reg = sum_reg + 2'(bus.need_reg[i]);
            sum_lsq = sum_lsq + 2'(bus.need_lsq[i]);
            sum_rob = sum_rob + 2'd1;
            if (sum_reg > c_reg) begin
               blocked    = 1'b1;
               reason_raw = 2'b01;
            end else if (sum_lsq > c_lsq) begin
               blocked    = 1'b1;
               reason_raw = 2'b10;
            end else if (sum_rob > c_rob) begin
               blocked    = 1'b1;
               reason_raw = 2'b11;
            end else begin
               grant_raw[i] = 1'b1;
            end
         end
      end
   end

   // Outputs: dispatch is suppressed during flush, recovery and while reset is held.
   always_comb begin
      run_ok             = reset && (state_q == StRun) && !bus.flush;
      grant              = run_ok ? grant_raw : 3'b000;
      accept             = run_ok && bus.group_valid && ((eff & ~grant_raw) == 3'b000);
      bus.dispatch_valid = grant;
      bus.group_accept   = accept;
      bus.stall_reason   = run_ok ? reason_raw : 2'b00;
      bus.recovering     = (state_q == StRecover);
      bus.stall_timeout  = stall_timeout_q;
   end

   // Control FSM: pending mask, recovery countdown and stall watchdog.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StRun;
         pending_q       <= 3'b111;
         rcnt_q          <= '0;
         wdog_q          <= '0;
         stall_timeout_q <= 1'b0;
      end else if (bus.flush) begin
         state_q         <= StRecover;
         pending_q       <= 3'b111;
         rcnt_q          <= RcntW'(FLUSH_WAIT);
         wdog_q          <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (accept) begin
                  pending_q <= 3'b111;
               end else if (grant != 3'b000) begin
                  pending_q <= pending_q & ~grant;
               end
               if (accept || (grant != 3'b000)) begin
                  wdog_q <= '0;
               end else if (eff != 3'b000) begin
                  if (wdog_q != STALL_W'(STALL_LIMIT)) wdog_q <= wdog_q + STALL_W'(1);
                  // Set on the same edge the count lands on the limit.
                  if (wdog_q >= STALL_W'(STALL_LIMIT - 1)) stall_timeout_q <= 1'b1;
               end
            end
            StRecover: begin
               if (rcnt_q == RcntW'(1)) state_q <= StRun;
               rcnt_q <= rcnt_q - RcntW'(1);
            end
            default: state_q <= StRun;
         endcase
      end
   end

`ifdef DISPATCH_PERF_CNT_EN
   // Wrapping performance counters; only reset clears them, flush does not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_disp_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         perf_disp_cnt <= perf_disp_cnt + 32'(grant[0]) + 32'(grant[1]) + 32'(grant[2]);
         if ((eff != 3'b000) && (grant == 3'b000)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rename_dispatch_controller.sv
// Directed bench for rename_dispatch_controller: single-cycle vector table plus
// hand-written multi-cycle sequences (partial group, flush recovery, watchdog, reset).
module tb_rename_dispatch_controller;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   rename_dispatch_controller_if #(.ROB_CNT_W(6)) bus ();

`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] perf_disp_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   rename_dispatch_controller #(
      .ROB_CNT_W   (6),
      .FLUSH_WAIT  (2),
      .STALL_LIMIT (255),
      .STALL_W     (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus)
`ifdef DISPATCH_PERF_CNT_EN
      ,
      .perf_disp_cnt  (perf_disp_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       gv;
      logic [2:0] sv;
      logic [2:0] nr;
      logic [2:0] nl;
      logic [2:0] ren;
      logic [2:0] lsq;
      logic [5:0] rob;
      logic [2:0] exp_dv;
      logic       exp_acc;
      logic [1:0] exp_rsn;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string name, input logic [2:0] dv, input logic acc,
                            input logic [1:0] rsn);
      check({name, ".dispatch_valid"}, 32'(bus.dispatch_valid), 32'(dv));
      check({name, ".group_accept"}, 32'(bus.group_accept), 32'(acc));
      check({name, ".stall_reason"}, 32'(bus.stall_reason), 32'(rsn));
   endtask

   task automatic drive(input logic gv, input logic [2:0] sv, input logic [2:0] nr,
                        input logic [2:0] nl, input logic [2:0] ren, input logic [2:0] lsq,
                        input logic [5:0] rob);
      bus.group_valid     = gv;
      bus.slot_valid      = sv;
      bus.need_reg        = nr;
      bus.need_lsq        = nl;
      bus.rename_ready    = ren;
      bus.lsq_alloc_ready = lsq;
      bus.rob_free_count  = rob;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flush pulse plus the recovery window, leaving RUN with pending=111 and wdog=0.
   task automatic drain();
      drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 6'd10);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.flush = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 6'd0);

      //               name        gv    sv      nr      nl      ren     lsq     rob    dv      acc   rsn
      vecs[0]  = '{"full",      1'b1, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 6'd10, 3'b111, 1'b1, 2'b00};
      vecs[1]  = '{"reg1",      1'b1, 3'b111, 3'b111, 3'b000, 3'b001, 3'b111, 6'd10, 3'b001, 1'b0, 2'b01};
      vecs[2]  = '{"noskip",    1'b1, 3'b111, 3'b010, 3'b001, 3'b000, 3'b111, 6'd10, 3'b001, 1'b0, 2'b01};
      vecs[3]  = '{"emptygrp",  1'b1, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 6'd0,  3'b000, 1'b1, 2'b00};
      vecs[4]  = '{"nogroup",   1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 6'd10, 3'b000, 1'b0, 2'b00};
      vecs[5]  = '{"lsq2",      1'b1, 3'b111, 3'b000, 3'b111, 3'b000, 3'b011, 6'd10, 3'b011, 1'b0, 2'b10};
      vecs[6]  = '{"rob2",      1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 6'd2,  3'b011, 1'b0, 2'b11};
      vecs[7]  = '{"rob0",      1'b1, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 6'd0,  3'b000, 1'b0, 2'b11};
      vecs[8]  = '{"gapslot",   1'b1, 3'b101, 3'b111, 3'b000, 3'b011, 3'b000, 6'd10, 3'b101, 1'b1, 2'b00};
      vecs[9]  = '{"prio_reg",  1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 6'd0,  3'b000, 1'b0, 2'b01};
      vecs[10] = '{"prio_lsq",  1'b1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 6'd0,  3'b000, 1'b0, 2'b10};
      vecs[11] = '{"mid_start", 1'b1, 3'b110, 3'b110, 3'b000, 3'b001, 3'b000, 6'd10, 3'b010, 1'b0, 2'b01};
      vecs[12] = '{"rob_max",   1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 6'd63, 3'b111, 1'b1, 2'b00};

      // Reset state
      reset = 1'b0;
      #12;
      check_out("reset", 3'b000, 1'b0, 2'b00);
      check("reset.recovering", 32'(bus.recovering), 32'd0);
      check("reset.stall_timeout", 32'(bus.stall_timeout), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Vector table: each vector starts from a fresh pending mask
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].gv, vecs[i].sv, vecs[i].nr, vecs[i].nl, vecs[i].ren, vecs[i].lsq,
               vecs[i].rob);
         #1;
         check_out(vecs[i].name, vecs[i].exp_dv, vecs[i].exp_acc, vecs[i].exp_rsn);
         step();
         drain();
      end

      // Partial group: leftover slots re-issued next cycle, then fresh group
      drive(1'b1, 3'b111, 3'b111, 3'b000, 3'b001, 3'b111, 6'd10);
      #1;
      check_out("partial.c0", 3'b001, 1'b0, 2'b01);
      step();
      bus.rename_ready = 3'b011;
      #1;
      check_out("partial.c1", 3'b110, 1'b1, 2'b00);
      step();
      #1;
      check_out("partial.c2", 3'b011, 1'b0, 2'b01);
      step();
      drain();

      // Flush during a partial group with pending=110
      drive(1'b1, 3'b111, 3'b111, 3'b000, 3'b001, 3'b111, 6'd10);
      step();
      bus.rename_ready = 3'b111;
      bus.flush = 1'b1;
      #1;
      check_out("flush.cyc", 3'b000, 1'b0, 2'b00);
      step();
      bus.flush = 1'b0;
      check("flush.rec1", 32'(bus.recovering), 32'd1);
      check_out("flush.rec1", 3'b000, 1'b0, 2'b00);
      step();
      check("flush.rec2", 32'(bus.recovering), 32'd1);
      check_out("flush.rec2", 3'b000, 1'b0, 2'b00);
      step();
      check("flush.run", 32'(bus.recovering), 32'd0);
      check_out("flush.run", 3'b111, 1'b1, 2'b00);
      step();
      drain();

      // Watchdog: ROB starved with a group held
      drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 6'd0);
      for (int i = 0; i < 254; i++) step();
      check("wdog.254", 32'(bus.stall_timeout), 32'd0);
      step();
      check("wdog.255", 32'(bus.stall_timeout), 32'd1);
      step();
      check("wdog.sat", 32'(bus.stall_timeout), 32'd1);
      bus.rob_free_count = 6'd10;
      #1;
      check_out("wdog.credit", 3'b111, 1'b1, 2'b00);
      step();
      check("wdog.sticky", 32'(bus.stall_timeout), 32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("wdog.flushclr", 32'(bus.stall_timeout), 32'd0);
      step();
      step();

      // Asynchronous reset with pending=100
      drive(1'b1, 3'b111, 3'b111, 3'b000, 3'b011, 3'b111, 6'd10);
      #1;
      check_out("rst.c0", 3'b011, 1'b0, 2'b01);
      step();
      bus.rename_ready = 3'b111;
      #1;
      check_out("rst.c1", 3'b100, 1'b1, 2'b00);
      #1;
      reset = 1'b0;
      #1;
      check_out("rst.async", 3'b000, 1'b0, 2'b00);
      #1;
      reset = 1'b1;
      step();
      check("rst.recovering", 32'(bus.recovering), 32'd0);
      check_out("rst.after", 3'b111, 1'b1, 2'b00);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
